// File: rtl/lsu_pkg.sv
// Shared load-store-unit definitions: access-size encodings, load-align FSM states
// and the size-to-byte-count helper.
package lsu_pkg;

  localparam logic [1:0] LSU_SZ_B = 2'd0;
  localparam logic [1:0] LSU_SZ_H = 2'd1;
  localparam logic [1:0] LSU_SZ_W = 2'd2;
  localparam logic [1:0] LSU_SZ_D = 2'd3;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RD0,
    LD_WT0,
    LD_RD1,
    LD_WT1,
    LD_RESP
  } lsu_ld_state_t;

  function automatic logic [3:0] lsu_nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_load_align_if.sv
// Request, data-memory read and writeback response signals of the load-align unit.
// The slave modport is the unit's own view; master is the surrounding pipeline/memory.
interface lsu_load_align_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);

  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic [1:0]      req_size;
  logic            req_unsigned;

  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rvalid;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_fault;

  modport slave (
    input  req_valid, req_addr, req_size, req_unsigned,
    input  mem_rdata, mem_rvalid,
    input  rsp_ready,
    output req_ready,
    output mem_rd_en, mem_addr,
    output rsp_valid, rsp_data, rsp_fault
  );

  modport master (
    output req_valid, req_addr, req_size, req_unsigned,
    output mem_rdata, mem_rvalid,
    output rsp_ready,
    input  req_ready,
    input  mem_rd_en, mem_addr,
    input  rsp_valid, rsp_data, rsp_fault
  );

endinterface

// File: rtl/lsu_ld_extract.sv
// Combinational byte/half/word/dword extractor: shifts the two-beat window down to the
// requested offset and zero- or sign-extends to XLEN. Shared with store forwarding.
module lsu_ld_extract
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]          beats,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [1:0]                 size,
  input  logic                       zero_ext,
  output logic [XLEN-1:0]            result
);

  logic [XLEN-1:0] lo;
  logic            sign_bit;
  int              nbits;

  always_comb begin
    lo       = XLEN'(beats >> {off, 3'b000});
    nbits    = 32'd8 << size;
    sign_bit = 1'b0;
    result   = '0;
    case (size)
      LSU_SZ_B: sign_bit = lo[7];
      LSU_SZ_H: sign_bit = lo[15];
      LSU_SZ_W: sign_bit = lo[31];
      default:  sign_bit = lo[XLEN-1];
    endcase
    if (zero_ext) sign_bit = 1'b0;
    // Bits above the access width take the extension bit.
    for (int i = 0; i < XLEN; i++) begin
      result[i] = (i < nbits) ? lo[i] : sign_bit;
    end
  end

endmodule

// File: rtl/lsu_load_align.sv
// Load-alignment unit: one request at a time, one or two aligned beat reads, then extract.
// LSU_MISALIGN_EN enables beat-crossing loads; otherwise misaligned requests fault.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input logic               clk,
  input logic               rst,
  lsu_load_align_if.slave   bus
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_ld_state_t   state_q, state_d;
  logic [OW-1:0]   off_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            fault_q;
  logic [AW-1:0]   mem_addr_q;
  logic [XLEN-1:0] beat0_q, beat1_q;
  logic [XLEN-1:0] ext_data;
  logic            req_illegal, req_misaligned, req_fault, accept;
`ifdef LSU_MISALIGN_EN
  logic            crosses;
`else
  logic [3:0]      req_nb;
`endif

  always_comb begin
    req_illegal = (bus.req_size == LSU_SZ_D) && (XLEN == 32);
`ifdef LSU_MISALIGN_EN
    req_misaligned = 1'b0;
    crosses = (int'(off_q) + int'(lsu_nbytes(size_q))) > NB;
`else
    req_nb = lsu_nbytes(bus.req_size);
    req_misaligned = |(bus.req_addr[2:0] & (req_nb[2:0] - 3'd1));
`endif
    req_fault = req_illegal | req_misaligned;
    accept = bus.req_valid && (state_q == LD_IDLE);
  end

  // Next-state decode; stray mem_rvalid outside the wait states is simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE: if (accept) state_d = req_fault ? LD_RESP : LD_RD0;
      LD_RD0:  state_d = LD_WT0;
      LD_WT0: begin
        if (bus.mem_rvalid) begin
`ifdef LSU_MISALIGN_EN
          state_d = crosses ? LD_RD1 : LD_RESP;
`else
          state_d = LD_RESP;
`endif
        end
      end
`ifdef LSU_MISALIGN_EN
      LD_RD1:  state_d = LD_WT1;
      LD_WT1:  if (bus.mem_rvalid) state_d = LD_RESP;
`endif
      LD_RESP: if (bus.rsp_ready) state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_IDLE;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      fault_q    <= 1'b0;
      mem_addr_q <= '0;
      beat0_q    <= '0;
      beat1_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q   <= bus.req_addr[OW-1:0];
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        fault_q <= req_fault;
        beat0_q <= '0;
        beat1_q <= '0;
        if (!req_fault) mem_addr_q <= bus.req_addr & ~AW'(NB - 1);
      end
      if (state_q == LD_WT0 && bus.mem_rvalid) beat0_q <= bus.mem_rdata;
`ifdef LSU_MISALIGN_EN
      // The second beat address wraps naturally at the top of the address space.
      if (state_q == LD_WT0 && bus.mem_rvalid && crosses) mem_addr_q <= mem_addr_q + AW'(NB);
      if (state_q == LD_WT1 && bus.mem_rvalid) beat1_q <= bus.mem_rdata;
`endif
    end
  end

  lsu_ld_extract #(.XLEN(XLEN)) u_extract (
    .beats    ({beat1_q, beat0_q}),
    .off      (off_q),
    .size     (size_q),
    .zero_ext (uns_q),
    .result   (ext_data)
  );

  assign bus.req_ready = (state_q == LD_IDLE);
  assign bus.mem_rd_en = (state_q == LD_RD0) || (state_q == LD_RD1);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = (state_q == LD_RESP);
  assign bus.rsp_fault = (state_q == LD_RESP) && fault_q;
  assign bus.rsp_data  = (state_q == LD_RESP && !fault_q) ? ext_data : '0;

endmodule

// File: tb/tb_lsu_load_align.sv
// Directed scoreboard bench for lsu_load_align at XLEN = 32 with a small latency-configurable
// memory responder; expectations follow LSU_MISALIGN_EN when it is defined.
module tb_lsu_load_align;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_load_align_if #(.XLEN(32), .AW(32)) bus ();

  lsu_load_align #(.XLEN(32), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          nstrobe;
    logic [31:0] saddr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] strobe_q[$];
  int          errors = 0;
  int          checks = 0;
  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h8765_4321;
      32'h104: return 32'hCAFE_BABE;
      default: return 32'h0;
    endcase
  endfunction

  // Memory model: records each strobe and answers mem_lat cycles later.
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'hDEAD_BEEF;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_word(pend_addr);
        end
      end
      if (bus.mem_rd_en === 1'b1) begin
        strobe_q.push_back(bus.mem_addr);
        pend_addr = bus.mem_addr;
        pend_cnt  = mem_lat;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] data, input logic fault,
                                input int lat, input int nstrobe, input logic [31:0] saddr);
    sb.push_back('{tag: tag, data: data, fault: fault, lat: lat, nstrobe: nstrobe, saddr: saddr});
    check({tag, "/req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_addr     = 32'hFFFF_FFFF;
  endtask

  task automatic check_output(input int hold);
    exp_t e;
    int   cyc;
    e   = sb.pop_front();
    cyc = 1;
    while (bus.rsp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({e.tag, "/rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({e.tag, "/latency"}, cyc, e.lat);
    check({e.tag, "/rsp_data"}, bus.rsp_data, e.data);
    check({e.tag, "/rsp_fault"}, {31'd0, bus.rsp_fault}, {31'd0, e.fault});
    check({e.tag, "/strobes"}, strobe_q.size(), e.nstrobe);
    if (strobe_q.size() > 0 && e.nstrobe > 0)
      check({e.tag, "/strobe0_addr"}, strobe_q[0], e.saddr);
    if (strobe_q.size() > 1 && e.nstrobe > 1)
      check({e.tag, "/strobe1_addr"}, strobe_q[1], e.saddr + 32'd4);
    strobe_q.delete();
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({e.tag, "/hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      check({e.tag, "/hold_data"}, bus.rsp_data, e.data);
      check({e.tag, "/hold_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({e.tag, "/post_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({e.tag, "/post_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "/req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, "/mem_rd_en"}, {31'd0, bus.mem_rd_en}, 32'd0);
    check({tag, "/mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "/rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "/rsp_data"}, bus.rsp_data, 32'd0);
    check({tag, "/rsp_fault"}, {31'd0, bus.rsp_fault}, 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = LSU_SZ_B;
    bus.req_unsigned = 1'b0;
    bus.rsp_ready    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");

    apply_stimulus("lb_103", 32'h103, LSU_SZ_B, 1'b0, 32'hFFFF_FF87, 1'b0, 3, 1, 32'h100);
    check_output(0);
    apply_stimulus("lhu_102", 32'h102, LSU_SZ_H, 1'b1, 32'h0000_8765, 1'b0, 3, 1, 32'h100);
    check_output(0);
`ifdef LSU_MISALIGN_EN
    apply_stimulus("lh_101", 32'h101, LSU_SZ_H, 1'b0, 32'h0000_6543, 1'b0, 3, 1, 32'h100);
    check_output(0);
    apply_stimulus("lw_102", 32'h102, LSU_SZ_W, 1'b0, 32'hBABE_8765, 1'b0, 5, 2, 32'h100);
    check_output(0);
    apply_stimulus("lh_103", 32'h103, LSU_SZ_H, 1'b0, 32'hFFFF_BE87, 1'b0, 5, 2, 32'h100);
    check_output(0);
`else
    apply_stimulus("lh_101", 32'h101, LSU_SZ_H, 1'b0, 32'h0, 1'b1, 1, 0, 32'h0);
    check_output(0);
    apply_stimulus("lw_102", 32'h102, LSU_SZ_W, 1'b0, 32'h0, 1'b1, 1, 0, 32'h0);
    check_output(0);
    apply_stimulus("lh_103", 32'h103, LSU_SZ_H, 1'b0, 32'h0, 1'b1, 1, 0, 32'h0);
    check_output(0);
`endif
    apply_stimulus("ld_100", 32'h100, LSU_SZ_D, 1'b0, 32'h0, 1'b1, 1, 0, 32'h0);
    check_output(0);

    mem_lat = 3;
    apply_stimulus("lw_104_bp", 32'h104, LSU_SZ_W, 1'b0, 32'hCAFE_BABE, 1'b0, 5, 1, 32'h104);
    check_output(3);
    mem_lat = 1;
    apply_stimulus("lb_107", 32'h107, LSU_SZ_B, 1'b0, 32'hFFFF_FFCA, 1'b0, 3, 1, 32'h104);
    check_output(0);
    apply_stimulus("lh_106", 32'h106, LSU_SZ_H, 1'b0, 32'hFFFF_CAFE, 1'b0, 3, 1, 32'h104);
    check_output(0);
    apply_stimulus("lbu_100", 32'h100, LSU_SZ_B, 1'b1, 32'h0000_0021, 1'b0, 3, 1, 32'h100);
    check_output(0);
    apply_stimulus("lhu_104", 32'h104, LSU_SZ_H, 1'b1, 32'h0000_BABE, 1'b0, 3, 1, 32'h104);
    check_output(0);

    // Reset while waiting for the first beat; the beat then arrives late in IDLE.
    mem_lat          = 3;
    bus.req_valid    = 1'b1;
    bus.req_addr     = 32'h100;
    bus.req_size     = LSU_SZ_W;
    bus.req_unsigned = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid    = 1'b0;
    @(negedge clk);
    check("rst_mid/wt0_no_valid", {31'd0, bus.rsp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_idle_outputs($sformatf("rst_mid_%0d", k));
    end
    strobe_q.delete();
    mem_lat = 1;
    apply_stimulus("lw_100_after_rst", 32'h100, LSU_SZ_W, 1'b0, 32'h8765_4321, 1'b0, 3, 1, 32'h100);
    check_output(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
